// File: rtl/adder_test_pkg.sv
// Shared definitions for the 16-bit prefix-adder self-test engine:
// operand and table sizes, the sweep FSM encoding, the 17-bit {cout,sum}
// result type and a behavioural reference adder.
package adder_test_pkg;

    localparam int unsigned WIDTH = 16;
    localparam int unsigned N_VEC = 16;
    localparam int unsigned IDX_W = $clog2(N_VEC);
    localparam int unsigned ERR_W = 10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef struct packed {
        logic             cout;
        logic [WIDTH-1:0] s;
    } result_t;

    // Golden result: {cout,sum} of a + b + cin.
    function automatic result_t add_ref(input logic [WIDTH-1:0] a,
                                        input logic [WIDTH-1:0] b,
                                        input logic             cin);
        logic [WIDTH:0] t;
        t = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
        return result_t'(t);
    endfunction

endpackage

// File: rtl/adder16_bist_vtab.sv
// Vector table: N_VEC x WIDTH register file with one synchronous write port
// and two combinational read ports (operand A index i, operand B index j).
// Contents are deliberately not reset so a loaded table survives a reset.
//   clk                   : clock
//   we, waddr, wdata      : write port
//   raddr_i, rdata_i_c    : read port for operand A
//   raddr_j, rdata_j_c    : read port for operand B
module adder16_bist_vtab
    import adder_test_pkg::*;
(
    input  logic             clk,
    input  logic             we,
    input  logic [IDX_W-1:0] waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [IDX_W-1:0] raddr_i,
    input  logic [IDX_W-1:0] raddr_j,
    output logic [WIDTH-1:0] rdata_i_c,
    output logic [WIDTH-1:0] rdata_j_c
);

    logic [WIDTH-1:0] mem [N_VEC];

    // Write port
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata_i_c = mem[raddr_i];
    assign rdata_j_c = mem[raddr_j];

endmodule

// File: rtl/adder16_bist.sv
// Built-in self-test engine for a 16-bit adder. Sweeps every (table[i],
// table[j]) operand pair with cin=0 then cin=1, holds the adder inputs for
// SETTLE cycles, compares {dut_cout,dut_s} against a behavioural sum and
// reports the error count plus the first failing pair.
//   clk, reset                : clock, synchronous active-high reset
//   start                     : begin a sweep (honoured in IDLE/DONE only)
//   vec_we/vec_addr/vec_wdata : vector table write port (ignored while busy)
//   dut_a, dut_b, dut_cin     : registered drive to the adder under test
//   dut_s, dut_cout           : adder response
//   busy, done, pass          : sweep status
//   err_count                 : number of mismatching pairs
//   ff_valid/ff_i/ff_j/ff_cin/ff_got : first recorded failure
module adder16_bist
    import adder_test_pkg::*;
#(
    parameter int unsigned SETTLE = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             vec_we,
    input  logic [IDX_W-1:0] vec_addr,
    input  logic [WIDTH-1:0] vec_wdata,
    output logic [WIDTH-1:0] dut_a,
    output logic [WIDTH-1:0] dut_b,
    output logic             dut_cin,
    input  logic [WIDTH-1:0] dut_s,
    input  logic             dut_cout,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic             ff_valid,
    output logic [IDX_W-1:0] ff_i,
    output logic [IDX_W-1:0] ff_j,
    output logic             ff_cin,
    output logic [WIDTH:0]   ff_got
);

    localparam int unsigned      CNT_W   = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CNT_W-1:0] CNT_END = CNT_W'(SETTLE - 1);
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(N_VEC - 1);

    state_t           state_q, state_d;
    logic [IDX_W-1:0] i_q, i_d, j_q, j_d;
    logic             cin_q, cin_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [WIDTH-1:0] dut_a_d, dut_b_d;
    logic             dut_cin_d;
    logic             busy_d, done_d, pass_d;
    logic [ERR_W-1:0] err_d;
    logic             ffv_d, ff_cin_d;
    logic [IDX_W-1:0] ff_i_d, ff_j_d;
    result_t          ff_got_d;

    logic [WIDTH-1:0] rd_i_c, rd_j_c;
    result_t          exp_c, got_c;
    logic             mismatch_c, last_pair_c;

    // Table reads follow the next-pair indices so the operands register
    // on the same edge that the pair starts.
    adder16_bist_vtab u_vtab (
        .clk       (clk),
        .we        (vec_we & ~busy),
        .waddr     (vec_addr),
        .wdata     (vec_wdata),
        .raddr_i   (i_d),
        .raddr_j   (j_d),
        .rdata_i_c (rd_i_c),
        .rdata_j_c (rd_j_c)
    );

    // Next-state and next-output logic
    always_comb begin
        state_d   = state_q;
        i_d       = i_q;
        j_d       = j_q;
        cin_d     = cin_q;
        cnt_d     = cnt_q;
        dut_a_d   = dut_a;
        dut_b_d   = dut_b;
        dut_cin_d = dut_cin;
        err_d     = err_count;
        ffv_d     = ff_valid;
        ff_i_d    = ff_i;
        ff_j_d    = ff_j;
        ff_cin_d  = ff_cin;
        ff_got_d  = result_t'(ff_got);

        exp_c       = add_ref(dut_a, dut_b, dut_cin);
        got_c       = result_t'({dut_cout, dut_s});
        mismatch_c  = (got_c != exp_c);
        last_pair_c = cin_q && (i_q == IDX_MAX) && (j_q == IDX_MAX);

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d  = DRIVE;
                    i_d      = '0;
                    j_d      = '0;
                    cin_d    = 1'b0;
                    cnt_d    = '0;
                    err_d    = '0;
                    ffv_d    = 1'b0;
                    ff_i_d   = '0;
                    ff_j_d   = '0;
                    ff_cin_d = 1'b0;
                    ff_got_d = '0;
                end
            end
            DRIVE: begin
                if (cnt_q == CNT_END) begin
                    cnt_d   = '0;
                    state_d = CHECK;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            CHECK: begin
                if (mismatch_c) begin
                    err_d = err_count + ERR_W'(1);
                    if (!ff_valid) begin
                        ffv_d    = 1'b1;
                        ff_i_d   = i_q;
                        ff_j_d   = j_q;
                        ff_cin_d = cin_q;
                        ff_got_d = got_c;
                    end
                end
                // cin outer, i middle, j inner
                if (last_pair_c) begin
                    state_d = DONE;
                end else begin
                    state_d = DRIVE;
                    j_d     = j_q + IDX_W'(1);
                    if (j_q == IDX_MAX) begin
                        i_d = i_q + IDX_W'(1);
                        if (i_q == IDX_MAX) begin
                            cin_d = 1'b1;
                        end
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (state_d == DRIVE) begin
            dut_a_d   = rd_i_c;
            dut_b_d   = rd_j_c;
            dut_cin_d = cin_d;
        end

        busy_d = (state_d == DRIVE) || (state_d == CHECK);
        done_d = (state_d == DONE);
        pass_d = done_d && (err_d == '0);
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            i_q       <= '0;
            j_q       <= '0;
            cin_q     <= 1'b0;
            cnt_q     <= '0;
            dut_a     <= '0;
            dut_b     <= '0;
            dut_cin   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_count <= '0;
            ff_valid  <= 1'b0;
            ff_i      <= '0;
            ff_j      <= '0;
            ff_cin    <= 1'b0;
            ff_got    <= '0;
        end else begin
            state_q   <= state_d;
            i_q       <= i_d;
            j_q       <= j_d;
            cin_q     <= cin_d;
            cnt_q     <= cnt_d;
            dut_a     <= dut_a_d;
            dut_b     <= dut_b_d;
            dut_cin   <= dut_cin_d;
            busy      <= busy_d;
            done      <= done_d;
            pass      <= pass_d;
            err_count <= err_d;
            ff_valid  <= ffv_d;
            ff_i      <= ff_i_d;
            ff_j      <= ff_j_d;
            ff_cin    <= ff_cin_d;
            ff_got    <= ff_got_d;
        end
    end

endmodule

// File: doc/adder16_bist.md
Name: adder16_bist

Overview:
- Synthesizable built-in self-test engine for the 16-bit prefix adders (BrentKung16, LadnerFischer16).
- Drives the adder inputs from an on-chip 16-entry vector table and sweeps every (A, B) pair, first with Cin=0 and then with Cin=1.
- Checks each {Cout,S} result against an internal behavioural sum and reports error count and first failure.
- Sits between the adder under test and a status/host interface.

Parameters:
- WIDTH, 16, operand width; fixed at 16 for this revision.
- N_VEC, 16, vector table depth; power of two; index width is log2(N_VEC).
- SETTLE, 2, cycles the adder inputs are held before sampling; minimum 1.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  begin a sweep; sampled only in IDLE or DONE.
- vec_we  in  1  vector table write enable.
- vec_addr  in  4  vector table write index.
- vec_wdata  in  16  vector table write data.
- dut_a  out  16  adder operand A.
- dut_b  out  16  adder operand B.
- dut_cin  out  1  adder carry-in.
- dut_s  in  16  adder sum.
- dut_cout  in  1  adder carry-out.
- busy  out  1  sweep in progress.
- done  out  1  sweep finished; held until the next start or reset.
- pass  out  1  valid when done=1; high when err_count is 0.
- err_count  out  10  number of mismatching pairs (maximum 512).
- ff_valid  out  1  at least one failure has been recorded.
- ff_i, ff_j  out  4 each  table indices of the first failure.
- ff_cin  out  1  Cin of the first failure.
- ff_got  out  17  {dut_cout,dut_s} captured at the first failure.

Behaviour:
- Reset:
  - FSM goes to IDLE.
  - All outputs are 0, including dut_a, dut_b and dut_cin.
  - Indices and settle counter are cleared.
  - Vector table contents are NOT cleared.
- Table write:
  - When vec_we=1 and busy=0, table[vec_addr] <= vec_wdata.
  - Writes while busy=1 are ignored.
- States and transitions:
  - IDLE: on start, clear err_count and the ff_* outputs, set cin=0, i=0, j=0, go to DRIVE.
  - DONE: behaves like IDLE on start, so a new sweep restarts from a cleared state.
  - DRIVE:
    - dut_a = table[i], dut_b = table[j], dut_cin = cin, all registered.
    - Hold for SETTLE cycles, counted by the settle counter, then go to CHECK.
  - CHECK:
    - Compare {dut_cout,dut_s} with exp = {1'b0,A} + {1'b0,B} + cin (17-bit).
    - On mismatch, increment err_count.
    - If ff_valid=0 on a mismatch, latch i, j, cin and the observed value, and set ff_valid.
    - Then advance: j increments; when j wraps, i increments; when i wraps, cin goes 0->1.
    - After the final pair (cin=1, i=15, j=15), go to DONE; otherwise go back to DRIVE.
- Sweep order: cin is the outer loop, i the middle loop, j the inner loop. Total 2*N_VEC*N_VEC = 512 pairs.
- Timing:
  - Each pair takes SETTLE+1 cycles.
  - If start is sampled at edge k, busy=1 from edge k.
  - DONE is entered and done=1 at edge k + 512*(SETTLE+1).
  - With SETTLE=2 this is k+1536.
- Status: busy=1 only in DRIVE and CHECK. pass = done & (err_count==0).
- start is ignored while busy=1.
- Reset during a sweep aborts it immediately; the sweep does not resume.
- err_count cannot overflow: 10 bits holds the maximum of 512.
- Comparison is an exact 17-bit equality; no don't-care bits.

Decomposition:
- Shared package adder_test_pkg holds:
  - WIDTH and N_VEC constants.
  - FSM state enum: IDLE, DRIVE, CHECK, DONE.
  - The 17-bit result type.
- One natural sub-module: adder16_bist_vtab, the 16x16 register file with a write port and two combinational read ports (i and j).
- Compare logic and FSM stay in the top module.

Test Plan:
- Ideal-adder model, table = 0000,FFFF,0001,8000,7FFF,5555,AAAA,00FF,FF00,1234,EDCB,0F0F,F0F0,8001,7FFE,0002; start -> done at start+1536, pass=1, err_count=0, ff_valid=0.
- Table all 8000, DUT cout stuck 0 -> err_count=512, ff_i=0, ff_j=0, ff_cin=0, ff_got=17'h00000.
- Table[0]=0001, others 0000, DUT S bit0 stuck 0 -> err_count=256, first failure i=0, j=1, cin=0, got 17'h00000.
- Start mid-sweep, and vec_we mid-sweep -> no restart, table unchanged; final results match the uninterrupted run.
- Reset asserted 100 cycles into a sweep -> next cycle busy=0, done=0, err_count=0, dut_a=0; table contents are preserved, so the next start gives the same results as before.
- Restart from DONE after a failing run -> counters clear on start; with a fault-free DUT the new run gives pass=1.
